// File: rtl/mux2x2_s.sv
// Registered 2:1 multiplexer with clock enable and synchronous active-low reset.
// Q comes straight from the flop; there is no combinational path from the inputs.
module mux2x2_s #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic             S,
  input  logic             CE,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_sel;

  // Whole word from one source, so the output bits are never mixed.
  assign w_sel = S ? D1 : D0;

  // Reset wins over the enable; with CE low the register holds its value.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_q <= '0;
    end else if (CE) begin
      r_q <= w_sel;
    end
  end

  assign Q = r_q;

endmodule

// File: tb/tb_mux2x2_s.sv
// Directed self-checking bench for mux2x2_s: reset, both selects, hold, and edge-only timing.
module tb_mux2x2_s;

  localparam int unsigned WIDTH = 2;

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] D0;
  logic [WIDTH-1:0] D1;
  logic             S;
  logic             CE;
  logic [WIDTH-1:0] Q;

  int checks;
  int errors;

  mux2x2_s #(.WIDTH(WIDTH)) dut (
    .CLK(CLK),
    .RST(RST),
    .D0 (D0),
    .D1 (D1),
    .S  (S),
    .CE (CE),
    .Q  (Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance past the next rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; CE = 1'b1; S = 1'b0; D0 = 2'd3; D1 = 2'd0;
    tick();
    checks++;
    if (Q !== 2'd3) begin
      errors++;
      $display("FAIL reset_preload1: got %0d expected %0d", Q, 2'd3);
    end
    RST = 1'b0; CE = 1'b1;
    tick();
    checks++;
    if (Q !== 2'd0) begin
      errors++;
      $display("FAIL reset_ce1: got %0d expected %0d", Q, 2'd0);
    end
    RST = 1'b1; CE = 1'b1; S = 1'b0; D0 = 2'd3;
    tick();
    checks++;
    if (Q !== 2'd3) begin
      errors++;
      $display("FAIL reset_preload2: got %0d expected %0d", Q, 2'd3);
    end
    RST = 1'b0; CE = 1'b0;
    tick();
    checks++;
    if (Q !== 2'd0) begin
      errors++;
      $display("FAIL reset_ce0: got %0d expected %0d", Q, 2'd0);
    end
  endtask

  task automatic test_select_d0();
    logic [WIDTH-1:0] d0_tab [4];
    logic [WIDTH-1:0] d1_tab [4];
    logic [WIDTH-1:0] exp_tab[4];
    d0_tab  = '{2'd0, 2'd1, 2'd2, 2'd3};
    d1_tab  = '{2'd3, 2'd2, 2'd1, 2'd0};
    exp_tab = '{2'd0, 2'd1, 2'd2, 2'd3};
    RST = 1'b1; CE = 1'b1; S = 1'b0;
    for (int i = 0; i < 4; i++) begin
      D0 = d0_tab[i]; D1 = d1_tab[i];
      tick();
      checks++;
      if (Q !== exp_tab[i]) begin
        errors++;
        $display("FAIL select_d0[%0d]: got %0d expected %0d", i, Q, exp_tab[i]);
      end
    end
  endtask

  task automatic test_select_d1();
    logic [WIDTH-1:0] d0_tab [4];
    logic [WIDTH-1:0] d1_tab [4];
    logic [WIDTH-1:0] exp_tab[4];
    d0_tab  = '{2'd0, 2'd1, 2'd2, 2'd3};
    d1_tab  = '{2'd3, 2'd2, 2'd1, 2'd0};
    exp_tab = '{2'd3, 2'd2, 2'd1, 2'd0};
    RST = 1'b1; CE = 1'b1; S = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D0 = d0_tab[i]; D1 = d1_tab[i];
      tick();
      checks++;
      if (Q !== exp_tab[i]) begin
        errors++;
        $display("FAIL select_d1[%0d]: got %0d expected %0d", i, Q, exp_tab[i]);
      end
    end
  endtask

  task automatic test_hold();
    RST = 1'b1; CE = 1'b1; S = 1'b0; D0 = 2'd2; D1 = 2'd1;
    tick();
    checks++;
    if (Q !== 2'd2) begin
      errors++;
      $display("FAIL hold_load: got %0d expected %0d", Q, 2'd2);
    end
    CE = 1'b0; D0 = 2'd1; D1 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      S = i[0];
      tick();
      checks++;
      if (Q !== 2'd2) begin
        errors++;
        $display("FAIL hold[%0d]: got %0d expected %0d", i, Q, 2'd2);
      end
    end
    CE = 1'b1; S = 1'b1;
    tick();
    checks++;
    if (Q !== 2'd3) begin
      errors++;
      $display("FAIL hold_release: got %0d expected %0d", Q, 2'd3);
    end
  endtask

  // Q is 3 on entry; all mid-cycle changes must be invisible until the next edge.
  task automatic test_sync_timing();
    S = 1'b0; D0 = 2'd1; D1 = 2'd2; CE = 1'b1;
    #2;
    checks++;
    if (Q !== 2'd3) begin
      errors++;
      $display("FAIL sync_midcycle_data: got %0d expected %0d", Q, 2'd3);
    end
    RST = 1'b0;
    #2;
    checks++;
    if (Q !== 2'd3) begin
      errors++;
      $display("FAIL sync_midcycle_rst: got %0d expected %0d", Q, 2'd3);
    end
    RST = 1'b1;
    tick();
    checks++;
    if (Q !== 2'd1) begin
      errors++;
      $display("FAIL sync_rst_pulse_ignored: got %0d expected %0d", Q, 2'd1);
    end
    // Reset held into an edge, then change S mid-cycle before it.
    RST = 1'b0; S = 1'b1;
    #3;
    checks++;
    if (Q !== 2'd1) begin
      errors++;
      $display("FAIL sync_before_rst_edge: got %0d expected %0d", Q, 2'd1);
    end
    tick();
    checks++;
    if (Q !== 2'd0) begin
      errors++;
      $display("FAIL sync_rst_edge: got %0d expected %0d", Q, 2'd0);
    end
    // First edge after reset loads normally.
    RST = 1'b1; CE = 1'b1; S = 1'b1; D1 = 2'd2;
    tick();
    checks++;
    if (Q !== 2'd2) begin
      errors++;
      $display("FAIL sync_first_after_rst: got %0d expected %0d", Q, 2'd2);
    end
    // Data changes between edges, output stable until next edge.
    S = 1'b0; D0 = 2'd1;
    #4;
    checks++;
    if (Q !== 2'd2) begin
      errors++;
      $display("FAIL sync_stable: got %0d expected %0d", Q, 2'd2);
    end
    tick();
    checks++;
    if (Q !== 2'd1) begin
      errors++;
      $display("FAIL sync_next_edge: got %0d expected %0d", Q, 2'd1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b0; CE = 1'b0; S = 1'b0; D0 = '0; D1 = '0;
    #1;
    test_reset();
    test_select_d0();
    test_select_d1();
    test_hold();
    test_sync_timing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
